// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - sequential instruction prefetch over AXI-lite read into a PC-tagged FIFO
//
// Fetches sequential instruction words at fetch_pc, one read outstanding at a
// time, and queues {instruction, pc, error} entries for the IDU.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   redirect_valid, redirect_pc     flush queue and restart fetch at redirect_pc
//   araddr, arvalid, arready        AXI-lite read address channel
//   rdata, rresp, rvalid, rready    AXI-lite read data channel
//   ifu_send_valid, ifu_receive_ready  head handshake toward the IDU
//   instruction, inst_pc, inst_err  head entry (holds last value when empty)
//   fifo_count                      occupied entries
//
// Optional build macro IFU_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt.

module ifu_prefetch #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic [ADDR_W-1:0]          araddr,
    output logic                       arvalid,
    input  logic                       arready,
    input  logic [DATA_W-1:0]          rdata,
    input  logic [1:0]                 rresp,
    input  logic                       rvalid,
    output logic                       rready,
    output logic                       ifu_send_valid,
    input  logic                       ifu_receive_ready,
    output logic [DATA_W-1:0]          instruction,
    output logic [ADDR_W-1:0]          inst_pc,
    output logic                       inst_err,
    output logic [$clog2(DEPTH):0]     fifo_count
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]                perf_fetch_cnt,
    output logic [31:0]                perf_stall_cnt
`endif
);

    localparam int                PW      = $clog2(DEPTH);
    localparam int                CW      = PW + 1;
    localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
    localparam logic [ADDR_W-1:0] INC     = ADDR_W'(DATA_W / 8);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              halted_q, halted_d;
    logic              drop_q, drop_d;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [ADDR_W-1:0] mem_pc   [DEPTH];
    logic              mem_err  [DEPTH];

    // Last head shown, so the outputs hold while the queue is empty.
    logic [DATA_W-1:0] hold_data_q;
    logic [ADDR_W-1:0] hold_pc_q;
    logic              hold_err_q;

    logic              push;
    logic              pop;
    logic              r_fire;
    logic              resp_err;

    assign r_fire   = rvalid && rready_q;
    assign resp_err = (rresp != 2'b00);

    // Fetch FSM and FIFO bookkeeping
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        araddr_d   = araddr_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        halted_d   = halted_q;
        drop_d     = drop_q;
        push       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A free slot now stays free until the response, since only
                // one read can be outstanding.
                if (!redirect_valid && !halted_q && (count_q < DEPTH_C)) begin
                    state_d   = S_ADDR;
                    araddr_d  = fetch_pc_q;
                    arvalid_d = 1'b1;
                end
            end
            S_ADDR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (r_fire) begin
                    rready_d = 1'b0;
                    drop_d   = 1'b0;
                    state_d  = S_IDLE;
                    if (!drop_q && !redirect_valid) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + INC;
                        if (resp_err) begin
                            halted_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Redirect overrides everything above. An address phase already on
        // the bus cannot be withdrawn, so its response is marked for discard.
        // A response consumed this very cycle leaves nothing to discard.
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            halted_d   = 1'b0;
            if ((state_q == S_ADDR) || ((state_q == S_DATA) && !r_fire)) begin
                drop_d = 1'b1;
            end
        end
    end

    always_comb begin
        pop      = (count_q != '0) && ifu_receive_ready && !redirect_valid;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            araddr_q   <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            halted_q   <= 1'b0;
            drop_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            araddr_q   <= araddr_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            halted_q   <= halted_d;
            drop_q     <= drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage is only ever read while count_q says the slot is occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr_q] <= rdata;
            mem_pc[wr_ptr_q]   <= fetch_pc_q;
            mem_err[wr_ptr_q]  <= resp_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data_q <= '0;
            hold_pc_q   <= '0;
            hold_err_q  <= 1'b0;
        end else begin
            hold_data_q <= instruction;
            hold_pc_q   <= inst_pc;
            hold_err_q  <= inst_err;
        end
    end

    assign ifu_send_valid = (count_q != '0);
    assign instruction    = ifu_send_valid ? mem_data[rd_ptr_q] : hold_data_q;
    assign inst_pc        = ifu_send_valid ? mem_pc[rd_ptr_q]   : hold_pc_q;
    assign inst_err       = ifu_send_valid ? mem_err[rd_ptr_q]  : hold_err_q;
    assign fifo_count     = count_q;
    assign araddr         = araddr_q;
    assign arvalid        = arvalid_q;
    assign rready         = rready_q;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (push) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (ifu_send_valid && !ifu_receive_ready) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb/tb_ifu_prefetch.sv - self-checking bench for ifu_prefetch with AXI-lite slave and queue model

module tb_ifu_prefetch;

    localparam int K_SV      = 0;
    localparam int K_NEW_AR  = 1;
    localparam int K_DATA_W  = 2;
    localparam int K_BLOCKED = 3;
    localparam int K_ERR     = 4;
    localparam int K_TWO     = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        ifu_send_valid;
    logic        ifu_receive_ready;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic        inst_err;
    logic [2:0]  fifo_count;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    ifu_prefetch dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .araddr            (araddr),
        .arvalid           (arvalid),
        .arready           (arready),
        .rdata             (rdata),
        .rresp             (rresp),
        .rvalid            (rvalid),
        .rready            (rready),
        .ifu_send_valid    (ifu_send_valid),
        .ifu_receive_ready (ifu_receive_ready),
        .instruction       (instruction),
        .inst_pc           (inst_pc),
        .inst_err          (inst_err),
        .fifo_count        (fifo_count)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt    (perf_fetch_cnt),
        .perf_stall_cnt    (perf_stall_cnt)
`endif
    );

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
        logic        err;
    } entry_t;

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] d1;
        logic [31:0] pc2;
        logic [31:0] d2;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // reference model state
    entry_t      q[$];
    entry_t      last_head;
    int          epoch = 0;
    logic [31:0] exp_ar_pc;
    bit          halted_m;
    bit          arv_prev;
    logic [31:0] ara_prev;
    int          cur_ar_epoch;
    int          ar_cnt;
    int          push_cnt;
    int          pop_total = 0;

    // slave state and knobs
    bit          s_pend;
    logic [31:0] s_addr;
    int          s_epoch;
    int          s_delay;
    bit          r_done;
    int          ar_pct;
    int          rd_min;
    int          rd_max;
    logic [31:0] err_addr;
    logic [31:0] block_addr;
    bit          rand_err;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a ^ 32'h8000_0000) + 32'h13;
    endfunction

    function automatic bit err_of(input logic [31:0] a);
        return (a == err_addr) || (rand_err && (a[6:2] == 5'd13));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cond(input int kind, input int lim, input string name);
        bit seen_low;
        bit hit;
        seen_low = !arvalid;
        hit      = 1'b0;
        for (int i = 0; i < lim && !hit; i++) begin
            step();
            case (kind)
                K_SV:      hit = ifu_send_valid;
                K_NEW_AR:  begin
                    if (!arvalid) seen_low = 1'b1;
                    else if (seen_low) hit = 1'b1;
                end
                K_DATA_W:  hit = rready && !rvalid;
                K_BLOCKED: hit = arvalid && (araddr == block_addr);
                K_ERR:     hit = ifu_send_valid && inst_err;
                K_TWO:     hit = (fifo_count >= 3'd2);
                default:   hit = 1'b1;
            endcase
        end
        if (!hit) begin
            total++;
            bad++;
            $display("FAIL timeout %s: condition not reached within %0d cycles", name, lim);
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    // AXI slave driving on negedge, reference model update before the next posedge
    always @(negedge clk) begin
        if (rst_n) begin
            if (r_done) begin
                rvalid = 1'b0;
                r_done = 1'b0;
            end
            arready = (araddr !== block_addr) && ($urandom_range(99) < ar_pct);
            if (s_pend && !rvalid) begin
                if (s_delay == 0) begin
                    rvalid = 1'b1;
                    rdata  = data_of(s_addr);
                    rresp  = err_of(s_addr) ? 2'd2 : 2'd0;
                end else begin
                    s_delay--;
                end
            end
        end
        #2;
        if (!rst_n) begin
            q.delete();
            last_head = '0;
            exp_ar_pc = 32'h8000_0000;
            halted_m  = 1'b0;
            arv_prev  = 1'b0;
            ara_prev  = '0;
            s_pend    = 1'b0;
            r_done    = 1'b0;
            rvalid    = 1'b0;
            arready   = 1'b0;
            ar_cnt    = 0;
            push_cnt  = 0;
            epoch++;
        end else begin
            entry_t exp_head;
            chk("fifo_count", 64'(fifo_count), 64'(q.size()));
            chk("send_valid", 64'(ifu_send_valid), 64'(q.size() != 0));
            exp_head  = (q.size() != 0) ? q[0] : last_head;
            last_head = exp_head;
            chk("head_instruction", 64'(instruction), 64'(exp_head.data));
            chk("head_pc", 64'(inst_pc), 64'(exp_head.pc));
            chk("head_err", 64'(inst_err), 64'(exp_head.err));

            if (arvalid && !arv_prev) begin
                ar_cnt++;
                chk("ar_addr", 64'(araddr), 64'(exp_ar_pc));
                chk("ar_while_halted", 64'(halted_m), 64'd0);
                cur_ar_epoch = epoch;
            end
            if (arvalid && arv_prev) begin
                chk("ar_stable", 64'(araddr), 64'(ara_prev));
            end

            if (arvalid && arready) begin
                s_pend  = 1'b1;
                s_addr  = araddr;
                s_epoch = cur_ar_epoch;
                s_delay = $urandom_range(rd_max, rd_min);
            end
            if (ifu_send_valid && ifu_receive_ready && !redirect_valid && q.size() != 0) begin
                void'(q.pop_front());
                pop_total++;
            end
            if (rvalid && rready) begin
                r_done = 1'b1;
                s_pend = 1'b0;
                if (s_epoch == epoch && !redirect_valid) begin
                    entry_t e;
                    e.data = rdata;
                    e.pc   = s_addr;
                    e.err  = (rresp != 2'd0);
                    q.push_back(e);
                    push_cnt++;
                    exp_ar_pc = s_addr + 32'd4;
                    if (e.err) halted_m = 1'b1;
                end
            end
            if (redirect_valid) begin
                q.delete();
                epoch++;
                exp_ar_pc = redirect_pc;
                halted_m  = 1'b0;
            end
            arv_prev = arvalid;
            ara_prev = araddr;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        vec_t vecs[4];
        int   n;
        vecs[0] = '{32'h8000_1000, 32'h0000_1013, 32'h8000_1004, 32'h0000_1017};
        vecs[1] = '{32'hFFFF_FFFC, 32'h8000_000F, 32'h0000_0000, 32'h8000_0013};
        vecs[2] = '{32'h8000_0102, 32'h0000_0115, 32'h8000_0106, 32'h0000_0119};
        vecs[3] = '{32'h0000_0000, 32'h8000_0013, 32'h0000_0004, 32'h8000_0017};

        rst_n             = 1'b0;
        redirect_valid    = 1'b0;
        redirect_pc       = '0;
        ifu_receive_ready = 1'b0;
        arready           = 1'b0;
        rvalid            = 1'b0;
        rdata             = '0;
        rresp             = '0;
        ar_pct            = 100;
        rd_min            = 0;
        rd_max            = 0;
        err_addr          = 32'hFFFF_FFFF;
        block_addr        = 32'hFFFF_FFFF;
        rand_err          = 1'b0;
        repeat (3) step();

        // reset values
        chk("rst_arvalid", 64'(arvalid), 64'd0);
        chk("rst_araddr", 64'(araddr), 64'd0);
        chk("rst_rready", 64'(rready), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_send_valid", 64'(ifu_send_valid), 64'd0);
        chk("rst_instruction", 64'(instruction), 64'd0);
        chk("rst_inst_pc", 64'(inst_pc), 64'd0);
        chk("rst_inst_err", 64'(inst_err), 64'd0);
        rst_n = 1'b1;

        // basic fetch
        ifu_receive_ready = 1'b1;
        wait_cond(K_NEW_AR, 20, "basic_first_ar");
        chk("basic_araddr0", 64'(araddr), 64'h8000_0000);
        wait_cond(K_SV, 20, "basic_first_entry");
        chk("basic_instruction", 64'(instruction), 64'h13);
        chk("basic_inst_pc", 64'(inst_pc), 64'h8000_0000);
        wait_cond(K_NEW_AR, 20, "basic_second_ar");
        chk("basic_araddr1", 64'(araddr), 64'h8000_0004);

        // backpressure fills exactly DEPTH entries, then drains in order
        do_reset();
        ifu_receive_ready = 1'b0;
        repeat (40) step();
        chk("bp_ar_count", 64'(ar_cnt), 64'd4);
        chk("bp_fifo_count", 64'(fifo_count), 64'd4);
        chk("bp_arvalid", 64'(arvalid), 64'd0);
        for (int k = 0; k < 4; k++) begin
            chk("bp_drain_pc", 64'(inst_pc), 64'(32'h8000_0000 + 32'(4 * k)));
            ifu_receive_ready = 1'b1;
            step();
        end

        // redirect while waiting for read data
        do_reset();
        ifu_receive_ready = 1'b1;
        rd_min = 6;
        rd_max = 6;
        wait_cond(K_DATA_W, 20, "rd_data_wait");
        do_redirect(32'h8000_1000);
        chk("rd_data_count", 64'(fifo_count), 64'd0);
        chk("rd_data_valid", 64'(ifu_send_valid), 64'd0);
        wait_cond(K_NEW_AR, 40, "rd_data_new_ar");
        chk("rd_data_araddr", 64'(araddr), 64'h8000_1000);
        wait_cond(K_SV, 40, "rd_data_entry");
        chk("rd_data_inst_pc", 64'(inst_pc), 64'h8000_1000);
        rd_min = 0;
        rd_max = 0;

        // redirect while the address phase is stalled
        do_reset();
        ifu_receive_ready = 1'b1;
        block_addr = 32'h8000_0008;
        wait_cond(K_BLOCKED, 40, "rd_addr_block");
        do_redirect(32'h8000_0200);
        for (int k = 0; k < 3; k++) begin
            chk("rd_addr_hold_valid", 64'(arvalid), 64'd1);
            chk("rd_addr_hold_addr", 64'(araddr), 64'h8000_0008);
            step();
        end
        block_addr = 32'hFFFF_FFFF;
        wait_cond(K_NEW_AR, 40, "rd_addr_new_ar");
        chk("rd_addr_araddr", 64'(araddr), 64'h8000_0200);
        wait_cond(K_SV, 40, "rd_addr_entry");
        chk("rd_addr_inst_pc", 64'(inst_pc), 64'h8000_0200);

        // bus error halts fetch until a redirect
        do_reset();
        ifu_receive_ready = 1'b1;
        err_addr = 32'h8000_0008;
        wait_cond(K_ERR, 40, "err_entry");
        chk("err_inst_pc", 64'(inst_pc), 64'h8000_0008);
        n = ar_cnt;
        repeat (20) step();
        chk("err_no_more_ar", 64'(ar_cnt), 64'(n));
        chk("err_arvalid", 64'(arvalid), 64'd0);
        do_redirect(32'h8000_0100);
        wait_cond(K_NEW_AR, 20, "err_resume_ar");
        chk("err_resume_araddr", 64'(araddr), 64'h8000_0100);
        wait_cond(K_SV, 20, "err_resume_entry");
        chk("err_resume_pc", 64'(inst_pc), 64'h8000_0100);
        chk("err_resume_err", 64'(inst_err), 64'd0);
        err_addr = 32'hFFFF_FFFF;

        // redirect boundary table: wrap, unaligned, zero
        do_reset();
        ifu_receive_ready = 1'b0;
        foreach (vecs[i]) begin
            do_redirect(vecs[i].rpc);
            wait_cond(K_TWO, 40, "vec_fill");
            chk("vec_pc1", 64'(inst_pc), 64'(vecs[i].rpc));
            chk("vec_d1", 64'(instruction), 64'(vecs[i].d1));
            ifu_receive_ready = 1'b1;
            step();
            ifu_receive_ready = 1'b0;
            chk("vec_pc2", 64'(inst_pc), 64'(vecs[i].pc2));
            chk("vec_d2", 64'(instruction), 64'(vecs[i].d2));
        end

`ifdef IFU_PERF_CNT_EN
        do_reset();
        ifu_receive_ready = 1'b0;
        wait_cond(K_SV, 20, "perf_first_entry");
        repeat (5) step();
        chk("perf_stall", 64'(perf_stall_cnt), 64'd5);
        chk("perf_fetch", 64'(perf_fetch_cnt), 64'(push_cnt));
`endif

        // randomized traffic against the model
        do_reset();
        ar_pct   = 70;
        rd_min   = 0;
        rd_max   = 3;
        rand_err = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            redirect_valid    = 1'b0;
            ifu_receive_ready = ($urandom_range(99) < 60);
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(999) == 0) begin
                rst_n = 1'b0;
            end else if ($urandom_range(99) < 3) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'h8000_0000 + ($urandom & 32'h0000_0FFC)
                                 + (($urandom_range(7) == 0) ? 32'd2 : 32'd0);
            end
            step();
        end
        redirect_valid = 1'b0;
        rst_n          = 1'b1;
        step();
        chk("random_progress", 64'(pop_total > 200), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
